custom_op_unit: RTL

Multi-cycle custom-instruction coprocessor for the 19-bit core. It replaces the combinational FFT/ENCRYPT/DECRYPT mux on the load-data path with a handshaked, parametrised unit. It accepts one operand and key per request and runs single-cycle bitwise operations or iterative keyed encrypt/decrypt rounds. It holds the result until the core acknowledges it.

---
 rtl/custom_op_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/custom_op_unit.sv
// custom_op_unit: handshaked custom-instruction coprocessor.
// Single-cycle ops (PASS/INV/REV) finish in one cycle. ENC/DEC run ROUNDS
// keyed rotate/xor rounds. The result is held in DONE until the core
// acknowledges it.
module custom_op_unit #(
    parameter int DATA_W = 19,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] key_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              err_o,
    input  logic              ack_i
);

    localparam int CNT_W = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_INV  = 3'b001;
    localparam logic [2:0] OP_ENC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_REV  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] key_q;
    logic              is_enc_q;

    function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], v[DATA_W-1]};
    endfunction

    function automatic logic [DATA_W-1:0] rotr1(input logic [DATA_W-1:0] v);
        return {v[0], v[DATA_W-1:1]};
    endfunction

    // ENC round: rotl1(x ^ key); DEC round: rotr1(x) ^ key (exact inverse).
    function automatic logic [DATA_W-1:0] round_step(
        input logic              enc,
        input logic [DATA_W-1:0] v,
        input logic [DATA_W-1:0] k
    );
        return enc ? rotl1(v ^ k) : (rotr1(v) ^ k);
    endfunction

    function automatic logic [DATA_W-1:0] single_op(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] v
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_PASS: r = v;
            OP_INV:  r = ~v;
            OP_REV:  r = {<<{v}};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            x        <= '0;
            key_q    <= '0;
            is_enc_q <= 1'b0;
            result_o <= '0;
            err_o    <= 1'b0;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        key_q    <= key_i;
                        is_enc_q <= (op_i == OP_ENC);
                        x        <= data_i;
                        ready_o  <= 1'b0;
                        if (op_i == OP_ENC || op_i == OP_DEC) begin
                            cnt    <= CNT_INIT;
                            busy_o <= 1'b1;
                            state  <= RUN;
                        end else begin
                            result_o <= single_op(op_i, data_i);
                            err_o    <= (op_i > OP_REV);
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                RUN: begin
                    x   <= round_step(is_enc_q, x, key_q);
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        result_o <= round_step(is_enc_q, x, key_q);
                        err_o    <= 1'b0;
                        busy_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
